// File: rtl/lif_layer.sv
// Layer of leaky integrate-and-fire neurons sharing one datapath; a tick walks the
// neurons one per cycle, then publishes the spike vector for that tick.
module lif_layer #(
    parameter int N_NEURONS = 8,
    parameter int STATE_W   = 16,
    parameter int REFRAC    = 2,
    localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int RC_W     = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [7:0]           current,
    input  logic [7:0]           beta,
    input  logic [STATE_W-1:0]   threshold,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [IDX_W-1:0]     state_sel,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes,
    output logic [7:0]           state_out,
    output logic                 overrun,
    output logic [1:0]           fsm_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_UPDATE = 2'd1, S_DONE = 2'd2} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 busy_q, done_q, overrun_q;
    logic [N_NEURONS-1:0] spikes_q, shadow_q;
    logic [7:0]           beta_q, state_out_q;
    logic [STATE_W-1:0]   thr_q;
    logic [STATE_W-1:0]   s_q  [N_NEURONS];
    logic [RC_W-1:0]      rc_q [N_NEURONS];
    logic [7:0]           w_q  [N_NEURONS];

    logic [15:0]          inp;
    logic [STATE_W+7:0]   dec;
    logic [STATE_W+8:0]   sum_raw;
    logic [STATE_W-1:0]   sum_sat, s_d;
    logic [RC_W-1:0]      rc_d;
    logic                 fire;
    logic [N_NEURONS-1:0] shadow_d;
    logic                 last_idx;

    // Datapath for the neuron at idx_q; the weight read here is the pre-write value.
    always_comb begin
        inp      = ({8'd0, current} * {8'd0, w_q[idx_q]}) >> 4;
        dec      = ({8'd0, s_q[idx_q]} * {{STATE_W{1'b0}}, beta_q}) >> 8;
        sum_raw  = {1'b0, dec} + {{(STATE_W-7){1'b0}}, inp};
        sum_sat  = (sum_raw > {9'd0, {STATE_W{1'b1}}}) ? {STATE_W{1'b1}} : sum_raw[STATE_W-1:0];
        fire     = 1'b0;
        s_d      = s_q[idx_q];
        rc_d     = rc_q[idx_q];
        if (rc_q[idx_q] != '0) begin
            rc_d = rc_q[idx_q] - 1'b1;
        end else if (sum_sat >= thr_q) begin
            fire = 1'b1;
            s_d  = sum_sat - thr_q;
            rc_d = RC_W'(REFRAC);
        end else begin
            s_d  = sum_sat;
        end
        shadow_d        = shadow_q;
        shadow_d[idx_q] = fire;
        last_idx        = (idx_q == IDX_W'(N_NEURONS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            spikes_q    <= '0;
            shadow_q    <= '0;
            beta_q      <= '0;
            thr_q       <= '0;
            state_out_q <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                s_q[k]  <= '0;
                rc_q[k] <= '0;
                w_q[k]  <= 8'd16;
            end
        end else begin
            state_out_q <= s_q[state_sel][STATE_W-1 -: 8];
            done_q      <= 1'b0;
            if (wr_en) w_q[wr_addr] <= wr_data;
            case (state_q)
                S_UPDATE: begin
                    if (tick) overrun_q <= 1'b1;
                    s_q[idx_q]  <= s_d;
                    rc_q[idx_q] <= rc_d;
                    shadow_q    <= shadow_d;
                    if (last_idx) begin
                        // Publish directly so spikes are already valid in the DONE cycle.
                        spikes_q <= shadow_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    if (tick) begin
                        beta_q  <= beta;
                        thr_q   <= threshold;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_UPDATE;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign spikes    = spikes_q;
    assign state_out = state_out_q;
    assign overrun   = overrun_q;
    assign fsm_state = state_q;
endmodule

// File: tb/tb_lif_layer.sv
// Bench for lif_layer: N=4, STATE_W=12, REFRAC=2; spike vectors go through an
// expected queue, membrane states are checked against a reference neuron model.
module tb_lif_layer;
    localparam int N  = 4;
    localparam int SW = 12;
    localparam int RF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [7:0]    current = '0;
    logic [7:0]    beta = '0;
    logic [SW-1:0] threshold = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [1:0]    state_sel = '0;
    logic          busy, done, overrun;
    logic [N-1:0]  spikes;
    logic [7:0]    state_out;
    logic [1:0]    fsm_state;

    int            m_s[N], m_rc[N], m_w[N];
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  last_spk;
    int            total = 0;
    int            bad = 0;

    lif_layer #(.N_NEURONS(N), .STATE_W(SW), .REFRAC(RF)) dut (
        .clk(clk), .rst(rst), .tick(tick), .current(current), .beta(beta),
        .threshold(threshold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .state_sel(state_sel), .busy(busy), .done(done), .spikes(spikes),
        .state_out(state_out), .overrun(overrun), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_s[k] = 0; m_rc[k] = 0; m_w[k] = 16;
        end
        last_spk = '0;
        exp_q.delete();
    endfunction

    function automatic logic [N-1:0] model_tick(int cur, int bt, int thr);
        logic [N-1:0] sp;
        int inp, dec, sum;
        sp = '0;
        for (int k = 0; k < N; k++) begin
            if (m_rc[k] != 0) begin
                m_rc[k] = m_rc[k] - 1;
            end else begin
                inp = (cur * m_w[k]) >> 4;
                dec = (m_s[k] * bt) >> 8;
                sum = dec + inp;
                if (sum > 4095) sum = 4095;
                if (sum >= thr) begin
                    sp[k] = 1'b1; m_s[k] = sum - thr; m_rc[k] = RF;
                end else begin
                    m_s[k] = sum;
                end
            end
        end
        return sp;
    endfunction

    task automatic write_weight(input int k, input int w);
        wr_en = 1'b1; wr_addr = 2'(k); wr_data = 8'(w);
        step();
        wr_en = 1'b0;
        m_w[k] = w;
    endtask

    task automatic check_states(input string name);
        logic [7:0] want;
        for (int k = 0; k < N; k++) begin
            state_sel = 2'(k);
            step();
            want = 8'((m_s[k] >> 4) & 255);
            total++;
            if (state_out !== want) begin
                bad++;
                $display("FAIL %s state_out[%0d]: got %0d want %0d", name, k, state_out, want);
            end
        end
    endtask

    // One accepted tick with cycle-exact timing checks; optionally a tick while
    // busy (overrun) and a weight write to neuron 0 while it is being updated.
    task automatic do_tick(input bit ov, input bit hz, input logic [7:0] hz_w);
        logic [N-1:0] want;
        exp_q.push_back(model_tick(int'(current), int'(beta), int'(threshold)));
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (hz) begin
            wr_en = 1'b1; wr_addr = 2'd0; wr_data = hz_w;
        end
        for (int i = 1; i <= N; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || spikes !== last_spk) begin
                bad++;
                $display("FAIL busy_window c%0d: busy=%b done=%b spikes=%b want busy=1 done=0 spikes=%b",
                         i, busy, done, spikes, last_spk);
            end
            if (i == 1 && ov) tick = 1'b1;
            step();
            tick = 1'b0;
            wr_en = 1'b0;
        end
        total++;
        if (done === 1'b1 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (spikes !== want || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_spikes: got spikes=%b busy=%b want spikes=%b busy=0", spikes, busy, want);
            end
            last_spk = want;
        end else begin
            bad++;
            $display("FAIL done_pulse: got done=%b want 1", done);
            if (exp_q.size() > 0) last_spk = exp_q.pop_front();
        end
        if (hz) m_w[0] = int'(hz_w);
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_width: got done=%b want 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_reset();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || spikes !== '0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b spikes=%b overrun=%b want all 0",
                     busy, done, spikes, overrun);
        end
        check_states("reset");
    endtask

    task automatic test_integrate_fire();
        current = 8'd100; beta = 8'd255; threshold = 12'd250;
        for (int t = 1; t <= 6; t++) begin
            do_tick(1'b0, 1'b0, 8'd0);
            if (t == 3) begin
                total++;
                if (spikes !== 4'hF) begin
                    bad++;
                    $display("FAIL fire_tick3: got %b want 1111", spikes);
                end
            end
            check_states("integrate");
        end
        state_sel = 2'd0;
        step();
        total++;
        if (state_out !== 8'd9) begin
            bad++;
            $display("FAIL state_tick6: got %0d want 9", state_out);
        end
    endtask

    task automatic test_saturation();
        test_reset();
        for (int k = 0; k < N; k++) write_weight(k, 255);
        current = 8'd255; beta = 8'd255; threshold = 12'hFFF;
        do_tick(1'b0, 1'b0, 8'd0);
        check_states("sat_t1");
        do_tick(1'b0, 1'b0, 8'd0);
        total++;
        if (spikes !== 4'hF) begin
            bad++;
            $display("FAIL sat_spike: got %b want 1111", spikes);
        end
        check_states("sat_t2");
    endtask

    task automatic test_overrun_hazard();
        test_reset();
        current = 8'd100; beta = 8'd128; threshold = 12'd4000;
        do_tick(1'b1, 1'b1, 8'd32);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        for (int i = 0; i < N + 2; i++) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL overrun_extra: done=%b busy=%b want 0 0", done, busy);
            end
            step();
        end
        check_states("hazard_old_w");
        do_tick(1'b0, 1'b0, 8'd0);
        check_states("hazard_new_w");
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        current = 8'd200; beta = 8'd200; threshold = 12'd100;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        total++;
        if (busy !== 1'b0 || spikes !== '0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b spikes=%b overrun=%b want 0", busy, spikes, overrun);
        end
        for (int i = 0; i < N + 2; i++) begin
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_done: got %b want 0", done);
            end
            step();
        end
        check_states("reset_mid");
    endtask

    task automatic test_random();
        test_reset();
        for (int t = 0; t < 16; t++) begin
            if (t % 4 == 0) write_weight($urandom_range(0, N - 1), $urandom_range(0, 255));
            current   = 8'($urandom_range(0, 255));
            beta      = 8'($urandom_range(0, 255));
            threshold = (t == 5) ? 12'd0 : 12'($urandom_range(0, 3000));
            do_tick(1'b0, 1'b0, 8'd0);
            check_states("random");
        end
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_saturation();
        test_overrun_hazard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
